// File: rtl/sonar_medidor_hcsr04_if.sv
// Purpose: signal bundle between one HC-SR04 front-end and its consumer.
// Latency: none, wires only.
// Backpressure: none; pronto is a single-cycle strobe with no ready.
interface sonar_medidor_hcsr04_if;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        timeout;
  logic        ocupado;
  logic [3:0]  db_estado;

  // Consumer side: requests measurements, drives the raw echo, reads results.
  modport master (
    output medir,
    output echo,
    input  trigger,
    input  medida,
    input  pronto,
    input  timeout,
    input  ocupado,
    input  db_estado
  );

  // Sensor front-end side.
  modport slave (
    input  medir,
    input  echo,
    output trigger,
    output medida,
    output pronto,
    output timeout,
    output ocupado,
    output db_estado
  );
endinterface

// File: rtl/sonar_medidor_hcsr04.sv
// Purpose: HC-SR04 front-end; fires trigger, times echo, outputs distance as 3 BCD digits (cm, rounded half-up).
// Latency: pronto rises 4 clocks after the raw echo falls (2 sync + round + final).
// Backpressure: none; medir is ignored while ocupado, result is a 1-cycle pronto strobe.
module sonar_medidor_hcsr04 #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TRIG_CLKS    = CLK_HZ / 100_000,
  parameter int CLKS_POR_CM  = 2941,
  parameter int TIMEOUT_CLKS = (CLK_HZ / 1000) * 30
) (
  input  logic                  clock,
  input  logic                  reset,
  sonar_medidor_hcsr04_if.slave bus
);

  // One timer serves both the trigger width and the echo timeouts, so it is
  // sized for the larger of the two.
  localparam int TMR_MAX = (TIMEOUT_CLKS > TRIG_CLKS) ? TIMEOUT_CLKS : TRIG_CLKS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TICK_W  = $clog2(CLKS_POR_CM + 1);

  localparam logic [TMR_W-1:0]  TRIG_LAST = TMR_W'(TRIG_CLKS - 1);
  localparam logic [TMR_W-1:0]  TOUT_LAST = TMR_W'(TIMEOUT_CLKS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_POR_CM - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_POR_CM / 2);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    TRIGGER     = 4'd2,
    ESPERA_ECHO = 4'd3,
    MEDE        = 4'd4,
    ARREDONDA   = 4'd5,
    FINAL       = 4'd6,
    FALHA       = 4'd7
  } estado_t;

  estado_t           state;
  estado_t           state_next;

  logic              echo_m;
  logic              echo_s;
  logic              echo_d;
  logic              echo_sobe;
  logic              echo_desce;

  logic [TMR_W-1:0]  tmr;
  logic [TICK_W-1:0] tick;
  logic [11:0]       cm;
  logic [11:0]       cm_inc;
  logic [11:0]       medida_r;
  logic              timeout_r;
  logic              trigger_r;
  logic              ocupado_c;
  logic              pronto_c;

  // BCD +1 across {centenas,dezenas,unidades}, sticking at 999 so an
  // over-range echo never wraps back to a small distance.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign cm_inc     = bcd_inc(cm);
  assign echo_sobe  = echo_s & ~echo_d;
  assign echo_desce = ~echo_s & echo_d;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INICIAL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an echo edge wins over a timeout landing on the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      INICIAL:     if (bus.medir) state_next = PREPARA;
      PREPARA:     state_next = TRIGGER;
      TRIGGER:     if (tmr == TRIG_LAST) state_next = ESPERA_ECHO;
      ESPERA_ECHO: begin
        if (echo_sobe)              state_next = MEDE;
        else if (tmr == TOUT_LAST)  state_next = FALHA;
      end
      MEDE: begin
        if (echo_desce)             state_next = ARREDONDA;
        else if (tmr == TOUT_LAST)  state_next = FALHA;
      end
      ARREDONDA:   state_next = FINAL;
      FINAL:       state_next = INICIAL;
      FALHA:       state_next = INICIAL;
      default:     state_next = INICIAL;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    ocupado_c = (state != INICIAL);
    pronto_c  = (state == FINAL) || (state == FALHA);
  end

  // Echo synchroniser, timers, BCD accumulator and result registers.
  // MEDE counts every cycle including the one that sees the fall, which
  // makes the tick total equal the echo width in clocks. medida and timeout
  // are loaded on the edge entering FINAL/FALHA so they are already valid
  // while pronto is high. trigger is registered from state_next so the pin
  // cannot glitch while the state code changes.
  always_ff @(posedge clock) begin
    if (reset) begin
      echo_m    <= 1'b0;
      echo_s    <= 1'b0;
      echo_d    <= 1'b0;
      tmr       <= '0;
      tick      <= '0;
      cm        <= 12'h000;
      medida_r  <= 12'h000;
      timeout_r <= 1'b0;
      trigger_r <= 1'b0;
    end else begin
      echo_m    <= bus.echo;
      echo_s    <= echo_m;
      echo_d    <= echo_s;
      trigger_r <= (state_next == TRIGGER);
      case (state)
        PREPARA: begin
          tmr       <= '0;
          tick      <= '0;
          cm        <= 12'h000;
          timeout_r <= 1'b0;
        end
        TRIGGER: begin
          tmr <= (state_next == TRIGGER) ? tmr + TMR_W'(1) : '0;
        end
        ESPERA_ECHO: begin
          tmr <= (state_next == ESPERA_ECHO) ? tmr + TMR_W'(1) : '0;
          if (state_next == FALHA) begin
            medida_r  <= 12'h999;
            timeout_r <= 1'b1;
          end
        end
        MEDE: begin
          tmr <= tmr + TMR_W'(1);
          if (tick == TICK_LAST) begin
            tick <= '0;
            cm   <= cm_inc;
          end else begin
            tick <= tick + TICK_W'(1);
          end
          if (state_next == FALHA) begin
            medida_r  <= 12'h999;
            timeout_r <= 1'b1;
          end
        end
        ARREDONDA: begin
          if (tick >= TICK_HALF) begin
            cm       <= cm_inc;
            medida_r <= cm_inc;
          end else begin
            medida_r <= cm;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.trigger   = trigger_r;
  assign bus.medida    = medida_r;
  assign bus.pronto    = pronto_c;
  assign bus.timeout   = timeout_r;
  assign bus.ocupado   = ocupado_c;
  assign bus.db_estado = state;

endmodule

// File: tb/tb_sonar_medidor_hcsr04.sv
// Purpose: self-checking bench for sonar_medidor_hcsr04 with scaled timing constants.
// Latency: checks pronto 4 clocks after raw echo fall and trigger width.
// Backpressure: checks medir is ignored while busy and one pronto per measurement.
module tb_sonar_medidor_hcsr04;
  localparam int TRIG = 10;
  localparam int CPC  = 20;
  localparam int TOUT = 2000;

  logic clock = 1'b0;
  logic reset;

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          cyc      = 0;
  int          n_pronto = 0;
  int          t_pronto = 0;
  logic [11:0] last_med = 12'h000;
  logic        last_to  = 1'b0;

  sonar_medidor_hcsr04_if bus();

  sonar_medidor_hcsr04 #(
    .CLK_HZ      (50_000_000),
    .TRIG_CLKS   (TRIG),
    .CLKS_POR_CM (CPC),
    .TIMEOUT_CLKS(TOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #10 clock = ~clock;

  // Cycle counter and pronto capture, sampled just after each rising edge.
  always @(posedge clock) begin
    #1;
    cyc = cyc + 1;
    if (bus.pronto === 1'b1) begin
      n_pronto = n_pronto + 1;
      t_pronto = cyc;
      last_med = bus.medida;
      last_to  = bus.timeout;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: width in clocks -> cm rounded half-up, saturating; 0 means no echo.
  function automatic logic [11:0] modelo(input int w);
    int cm;
    if (w == 0 || w > TOUT) return 12'h999;
    cm = w / CPC;
    if ((w % CPC) >= CPC / 2) cm = cm + 1;
    if (cm > 999) cm = 999;
    return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
  endfunction

  // One full measurement: request, trigger check, echo of w clocks (0 = none), result check.
  task automatic medir_eco(input int w, input int atraso, input bit cutuca);
    int          n0;
    int          k;
    int          tw;
    int          t_tf;
    int          t_drop;
    logic [11:0] exp_med;
    logic        exp_to;
    n0      = n_pronto;
    exp_med = modelo(w);
    exp_to  = (w == 0 || w > TOUT);
    @(negedge clock); bus.medir = 1'b1;
    @(negedge clock); bus.medir = 1'b0;
    k = 0;
    while (bus.trigger !== 1'b1 && k < 10) begin @(negedge clock); k++; end
    tw = 0;
    while (bus.trigger === 1'b1 && tw < 1000) begin @(negedge clock); tw++; end
    check("trigger_width", tw, TRIG);
    t_tf = cyc;
    repeat (atraso) @(negedge clock);
    if (w > 0) begin
      bus.echo = 1'b1;
      for (int i = 0; i < w; i++) begin
        @(negedge clock);
        bus.medir = (cutuca && i == w / 2);
      end
      bus.medir = 1'b0;
      if (w >= 3 && w <= TOUT) check("estado_mede", bus.db_estado, 4);
      bus.echo = 1'b0;
    end
    t_drop = cyc;
    k = 0;
    while (n_pronto == n0 && k < TOUT + 200) begin @(negedge clock); k++; end
    check("pronto_chegou", (n_pronto > n0), 1);
    if (w == 0) check("atraso_timeout", t_pronto - t_tf, TOUT);
    else if (!exp_to) check("latencia_pronto", t_pronto - t_drop, 4);
    check("medida", last_med, exp_med);
    check("timeout", last_to, exp_to);
    repeat (8) @(negedge clock);
    check("um_pronto", n_pronto - n0, 1);
    check("ocioso", bus.ocupado, 0);
    check("medida_mantida", bus.medida, exp_med);
    check("timeout_mantido", bus.timeout, exp_to);
  endtask

  initial begin
    int n0;
    int k;
    reset     = 1'b1;
    bus.medir = 1'b0;
    bus.echo  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_trigger", bus.trigger, 0);
    check("rst_medida", bus.medida, 12'h000);
    check("rst_pronto", bus.pronto, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_ocupado", bus.ocupado, 0);
    check("rst_estado", bus.db_estado, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    medir_eco(200, 5, 1'b0);    // 10 cm
    medir_eco(240, 0, 1'b0);    // 12 cm
    medir_eco(1480, 3, 1'b0);   // 74 cm
    medir_eco(1496, 7, 1'b0);   // 74.8 cm rounds up
    medir_eco(9, 2, 1'b0);      // 0.45 cm rounds down
    medir_eco(10, 2, 1'b0);     // 0.5 cm rounds up
    medir_eco(0, 0, 1'b0);      // no echo
    medir_eco(200, 4, 1'b0);    // good echo clears timeout
    medir_eco(2100, 1, 1'b0);   // echo held too long
    medir_eco(500, 6, 1'b1);    // medir poked mid-echo

    // Reset while measuring aborts with no pronto.
    n0 = n_pronto;
    @(negedge clock); bus.medir = 1'b1;
    @(negedge clock); bus.medir = 1'b0;
    k = 0;
    while (bus.trigger !== 1'b1 && k < 10) begin @(negedge clock); k++; end
    k = 0;
    while (bus.trigger === 1'b1 && k < 1000) begin @(negedge clock); k++; end
    bus.echo = 1'b1;
    repeat (20) @(negedge clock);
    check("pre_rst_estado", bus.db_estado, 4);
    reset = 1'b1;
    @(negedge clock);
    check("mrst_trigger", bus.trigger, 0);
    check("mrst_medida", bus.medida, 12'h000);
    check("mrst_pronto", bus.pronto, 0);
    check("mrst_timeout", bus.timeout, 0);
    check("mrst_ocupado", bus.ocupado, 0);
    check("mrst_estado", bus.db_estado, 0);
    bus.echo = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("mrst_sem_pronto", n_pronto - n0, 0);

    for (int r = 0; r < 10; r++) begin
      medir_eco(int'($urandom_range(1990, 1)), int'($urandom_range(30, 0)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog cyc=%0d limit_reached", cyc);
    $fatal(1, "watchdog");
  end
endmodule
